// File: rtl/emif_lb_pkg.sv
// emif_lb_pkg
//   Shared types and constants for the linebuffer EMIF arbiter slice.
//   - arb_state_t  : command-bus ownership state of the arbiter
//   - EMIF_*_W     : default Avalon widths (word address, data, burstcount)
//   - EMIF_LB_BASE : top address bits of the linebuffer region in EMIF space
package emif_lb_pkg;

   localparam int EMIF_ADDR_W = 28;
   localparam int EMIF_DATA_W = 256;
   localparam int EMIF_BC_W   = 6;

   // Linebuffer region occupies the 3 MSBs of the 28-bit word address.
   localparam logic [2:0] EMIF_LB_BASE = 3'b001;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_CMD   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/emif_lb_arbiter_if.sv
// emif_lb_arbiter_if
//   Bundle of the three Avalon-MM burst ports around the arbiter:
//   write master (wr_*), read master (rd_* plus rd_urgent) and EMIF bridge
//   (emif_*).
//   Handshake: a command transfers on a cycle where read/write is high and
//   waitrequest is low; while waitrequest is high the master holds address,
//   burstcount and write data stable. Read data has no back-pressure: a beat
//   is delivered on every cycle with readdatavalid high.
//   Modports:
//   - slave  : the arbiter's view (consumes master commands, drives EMIF)
//   - master : the system's view (the two masters and the EMIF bridge)
interface emif_lb_arbiter_if import emif_lb_pkg::*; #(
   parameter int ADDR_W = EMIF_ADDR_W,
   parameter int DATA_W = EMIF_DATA_W,
   parameter int BC_W   = EMIF_BC_W
);

   logic [ADDR_W-1:0] wr_addr;
   logic              wr_write;
   logic [BC_W-1:0]   wr_burstcount;
   logic [DATA_W-1:0] wr_wdata;
   logic              wr_waitrequest;

   logic [ADDR_W-1:0] rd_addr;
   logic              rd_read;
   logic [BC_W-1:0]   rd_burstcount;
   logic              rd_waitrequest;
   logic [DATA_W-1:0] rd_rdata;
   logic              rd_readdatavalid;
   logic              rd_urgent;

   logic [ADDR_W-1:0] emif_addr;
   logic              emif_read;
   logic              emif_write;
   logic [BC_W-1:0]   emif_burstcount;
   logic [DATA_W-1:0] emif_wdata;
   logic              emif_waitrequest;
   logic [DATA_W-1:0] emif_rdata;
   logic              emif_readdatavalid;

   modport slave (
      input  wr_addr, wr_write, wr_burstcount, wr_wdata,
      input  rd_addr, rd_read, rd_burstcount, rd_urgent,
      input  emif_waitrequest, emif_rdata, emif_readdatavalid,
      output wr_waitrequest, rd_waitrequest, rd_rdata, rd_readdatavalid,
      output emif_addr, emif_read, emif_write, emif_burstcount, emif_wdata
   );

   modport master (
      output wr_addr, wr_write, wr_burstcount, wr_wdata,
      output rd_addr, rd_read, rd_burstcount, rd_urgent,
      output emif_waitrequest, emif_rdata, emif_readdatavalid,
      input  wr_waitrequest, rd_waitrequest, rd_rdata, rd_readdatavalid,
      input  emif_addr, emif_read, emif_write, emif_burstcount, emif_wdata
   );

endinterface

// File: rtl/emif_rd_credit.sv
// emif_rd_credit
//   Counts read beats in flight between command acceptance and data return.
//   Ports:
//   - i_clk, i_rst        : clock, async active-high reset
//   - i_add, i_add_bc     : read command accepted with this burstcount
//   - i_sub               : one read beat returned this cycle
//   - i_check_bc          : burstcount to test against the credit limit
//   - o_cnt               : beats currently in flight
//   - o_can_issue         : o_cnt + i_check_bc fits within MAX_OUT
//   - o_err_underflow     : sticky, a beat returned with nothing in flight
module emif_rd_credit #(
   parameter int BC_W    = 6,
   parameter int CNT_W   = 7,
   parameter int MAX_OUT = 64
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_add,
   input  logic [BC_W-1:0]  i_add_bc,
   input  logic             i_sub,
   input  logic [BC_W-1:0]  i_check_bc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_can_issue,
   output logic             o_err_underflow
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W:0]   w_check;
   logic [CNT_W-1:0] w_next;
   logic             w_underflow;

   // Add first, then subtract: a same-cycle accept and return nets to
   // cnt + bc - 1 and only underflows if nothing was in flight at all.
   assign w_sum       = {1'b0, r_cnt} + (i_add ? (CNT_W+1)'(i_add_bc) : '0);
   assign w_underflow = i_sub && (w_sum == '0);
   assign w_next      = w_underflow ? '0 :
                        CNT_W'(i_sub ? (w_sum - (CNT_W+1)'(1)) : w_sum);

   assign w_check     = {1'b0, r_cnt} + (CNT_W+1)'(i_check_bc);
   assign o_can_issue = (w_check <= (CNT_W+1)'(MAX_OUT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_next;
         if (w_underflow) r_err <= 1'b1;
      end
   end

   assign o_cnt           = r_cnt;
   assign o_err_underflow = r_err;

endmodule

// File: rtl/emif_lb_arbiter.sv
// emif_lb_arbiter
//   Shares one EMIF Avalon-MM burst port between the linebuffer capture-write
//   master and output-read master. A write owns the bus for its whole burst;
//   a read owns it only for its command cycle. Read beats in flight are
//   capped, and rd_urgent lets the read side win ties in IDLE.
//   Ports:
//   - emif_br_clk, emif_br_reset : clock, async active-high reset
//   - bus                        : wr_*/rd_*/emif_* ports (slave modport)
//   - rd_outstanding             : read beats in flight
//   - grant_wr, grant_rd         : current command-bus owner
//   - dbg_state                  : FSM state
//   - dbg_err_underflow          : sticky, read beat returned at count 0
module emif_lb_arbiter import emif_lb_pkg::*; #(
   parameter int BC_W               = EMIF_BC_W,
   parameter int MAX_BURST          = 32,
   parameter int RD_MAX_OUTSTANDING = 64
)(
   input  logic                    emif_br_clk,
   input  logic                    emif_br_reset,
   emif_lb_arbiter_if.slave        bus,
   output logic [6:0]              rd_outstanding,
   output logic                    grant_wr,
   output logic                    grant_rd,
   output arb_state_t              dbg_state,
   output logic                    dbg_err_underflow
);

   arb_state_t      r_state, w_next_state;
   logic [BC_W-1:0] r_beats, w_beats_next;
   logic            r_last_rd, w_last_rd_next;   // 0: write granted last
   logic            w_rd_add;
   logic            w_can_issue;
   logic            w_wr_req, w_rd_req;
   logic            w_pick_wr, w_pick_rd;

   emif_rd_credit #(
      .BC_W    (BC_W),
      .CNT_W   (7),
      .MAX_OUT (RD_MAX_OUTSTANDING)
   ) u_credit (
      .i_clk           (emif_br_clk),
      .i_rst           (emif_br_reset),
      .i_add           (w_rd_add),
      .i_add_bc        (bus.rd_burstcount),
      .i_sub           (bus.emif_readdatavalid),
      .i_check_bc      (bus.rd_burstcount),
      .o_cnt           (rd_outstanding),
      .o_can_issue     (w_can_issue),
      .o_err_underflow (dbg_err_underflow)
   );

   // Illegal burstcounts are simply never granted; the master stalls.
   assign w_wr_req = bus.wr_write && (bus.wr_burstcount != '0) &&
                     (32'(bus.wr_burstcount) <= 32'(MAX_BURST));
   assign w_rd_req = bus.rd_read && (bus.rd_burstcount != '0) &&
                     (32'(bus.rd_burstcount) <= 32'(MAX_BURST)) && w_can_issue;

   // Read wins a tie when urgent or when write had the previous grant.
   assign w_pick_rd = w_rd_req && (!w_wr_req || bus.rd_urgent || !r_last_rd);
   assign w_pick_wr = w_wr_req && !w_pick_rd;

   always_ff @(posedge emif_br_clk or posedge emif_br_reset) begin
      if (emif_br_reset) begin
         r_state   <= IDLE;
         r_beats   <= '0;
         r_last_rd <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_beats   <= w_beats_next;
         r_last_rd <= w_last_rd_next;
      end
   end

   always_comb begin
      w_next_state        = r_state;
      w_beats_next        = r_beats;
      w_last_rd_next      = r_last_rd;
      w_rd_add            = 1'b0;
      // Idle bus still carries the write master's address/data.
      bus.emif_addr       = bus.wr_addr;
      bus.emif_burstcount = bus.wr_burstcount;
      bus.emif_wdata      = bus.wr_wdata;
      bus.emif_read       = 1'b0;
      bus.emif_write      = 1'b0;
      bus.wr_waitrequest  = 1'b1;
      bus.rd_waitrequest  = 1'b1;

      case (r_state)
         IDLE: begin
            if (w_pick_rd) begin
               w_next_state   = RD_CMD;
               w_last_rd_next = 1'b1;
            end else if (w_pick_wr) begin
               w_next_state   = WR_BURST;
               w_beats_next   = bus.wr_burstcount;
               w_last_rd_next = 1'b0;
            end
         end
         WR_BURST: begin
            bus.emif_write     = bus.wr_write;
            bus.wr_waitrequest = bus.emif_waitrequest;
            if (bus.wr_write && !bus.emif_waitrequest) begin
               w_beats_next = r_beats - BC_W'(1);
               if (r_beats == BC_W'(1)) w_next_state = IDLE;
            end
         end
         RD_CMD: begin
            bus.emif_addr       = bus.rd_addr;
            bus.emif_burstcount = bus.rd_burstcount;
            bus.emif_read       = bus.rd_read;
            bus.rd_waitrequest  = bus.emif_waitrequest;
            if (bus.rd_read && !bus.emif_waitrequest) begin
               w_rd_add     = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign bus.rd_rdata         = bus.emif_rdata;
   assign bus.rd_readdatavalid = bus.emif_readdatavalid;

   assign grant_wr  = (r_state == WR_BURST);
   assign grant_rd  = (r_state == RD_CMD);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_emif_lb_arbiter.sv
// tb_emif_lb_arbiter
//   Directed scenarios followed by a randomized run. A cycle-level reference
//   model of bus ownership and read credit (plain integers) predicts every
//   output; write data ordering is scoreboarded through exp_q.
module tb_emif_lb_arbiter;
   import emif_lb_pkg::*;

   logic       clk;
   logic       rst;
   logic [6:0] rd_outstanding;
   logic       grant_wr, grant_rd, dbg_err;
   arb_state_t dbg_state;

   emif_lb_arbiter_if bus ();

   emif_lb_arbiter dut (
      .emif_br_clk       (clk),
      .emif_br_reset     (rst),
      .bus               (bus),
      .rd_outstanding    (rd_outstanding),
      .grant_wr          (grant_wr),
      .grant_rd          (grant_rd),
      .dbg_state         (dbg_state),
      .dbg_err_underflow (dbg_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   bit last_acc_wr, last_acc_rd;
   bit sb_on = 0;
   bit log_on = 0;
   int g_who[$];
   int g_cyc[$];
   logic [255:0] exp_q[$];

   // reference model: owner 0 = none, 1 = write, 2 = read
   int m_owner, m_left, m_out;
   bit m_last_rd, m_err;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_left = 0; m_out = 0; m_last_rd = 0; m_err = 0;
   endtask

   function automatic arb_state_t exp_state();
      if (m_owner == 1) return WR_BURST;
      if (m_owner == 2) return RD_CMD;
      return IDLE;
   endfunction

   task automatic check_outputs();
      chk("wr_waitrequest", bus.wr_waitrequest, (m_owner == 1) ? bus.emif_waitrequest : 1'b1);
      chk("rd_waitrequest", bus.rd_waitrequest, (m_owner == 2) ? bus.emif_waitrequest : 1'b1);
      chk("emif_write", bus.emif_write, (m_owner == 1) && bus.wr_write);
      chk("emif_read", bus.emif_read, (m_owner == 2) && bus.rd_read);
      if (m_owner != 0) begin
         chk("emif_addr", bus.emif_addr, (m_owner == 2) ? bus.rd_addr : bus.wr_addr);
         chk("emif_burstcount", bus.emif_burstcount,
             (m_owner == 2) ? bus.rd_burstcount : bus.wr_burstcount);
      end
      if (m_owner == 1) chk("emif_wdata", bus.emif_wdata, bus.wr_wdata);
      chk("rd_rdata", bus.rd_rdata, bus.emif_rdata);
      chk("rd_readdatavalid", bus.rd_readdatavalid, bus.emif_readdatavalid);
      chk("rd_outstanding", rd_outstanding, m_out);
      chk("grant_wr", grant_wr, m_owner == 1);
      chk("grant_rd", grant_rd, m_owner == 2);
      chk("dbg_state", dbg_state, exp_state());
      chk("err_underflow", dbg_err, m_err);
   endtask

   // Advance the model over one rising edge using the current inputs.
   task automatic model_update();
      int  add;
      bit  wv, rv;
      add = 0;
      if (rst) begin
         model_reset();
         return;
      end
      case (m_owner)
         0: begin
            wv = bus.wr_write && bus.wr_burstcount >= 1 && bus.wr_burstcount <= 32;
            rv = bus.rd_read && bus.rd_burstcount >= 1 && bus.rd_burstcount <= 32 &&
                 (m_out + int'(bus.rd_burstcount) <= 64);
            if (wv && rv) begin
               // tie: urgent read wins, otherwise whoever lost last time
               if (bus.rd_urgent) m_owner = 2;
               else m_owner = m_last_rd ? 1 : 2;
            end else if (wv) m_owner = 1;
            else if (rv) m_owner = 2;
            if (m_owner == 1) begin
               m_left = int'(bus.wr_burstcount);
               m_last_rd = 0;
            end
            if (m_owner == 2) m_last_rd = 1;
         end
         1: if (bus.wr_write && !bus.emif_waitrequest) begin
            m_left--;
            if (m_left == 0) m_owner = 0;
         end
         default: if (bus.rd_read && !bus.emif_waitrequest) begin
            add = int'(bus.rd_burstcount);
            m_owner = 0;
         end
      endcase
      m_out += add;
      if (bus.emif_readdatavalid) begin
         if (m_out == 0) m_err = 1;
         else m_out--;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      last_acc_wr = bus.emif_write && !bus.emif_waitrequest;
      last_acc_rd = bus.emif_read && !bus.emif_waitrequest;
      if (last_acc_wr) begin
         acc_cnt++;
         if (sb_on && exp_q.size() > 0) chk("wdata_order", bus.emif_wdata, exp_q.pop_front());
      end
      if (log_on && (grant_wr || grant_rd)) begin
         g_who.push_back(grant_rd ? 2 : 1);
         g_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_addr = '0; bus.wr_write = 0; bus.wr_burstcount = '0; bus.wr_wdata = '0;
      bus.rd_addr = '0; bus.rd_read = 0; bus.rd_burstcount = '0; bus.rd_urgent = 0;
      bus.emif_waitrequest = 0; bus.emif_rdata = '0; bus.emif_readdatavalid = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      model_reset();
      step();
      step();
      rst = 0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         bus.emif_readdatavalid = 1;
         bus.emif_rdata = {8{$urandom}};
         step();
      end
      bus.emif_readdatavalid = 0;
   endtask

   function automatic logic [255:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus ----------------
   logic [255:0] data_arr[32];

   initial begin
      int k, n;
      rst = 1;
      idle_inputs();
      model_reset();
      #1;
      chk("reset_wr_wait", bus.wr_waitrequest, 1'b1);
      chk("reset_rd_wait", bus.rd_waitrequest, 1'b1);
      chk("reset_emif_write", bus.emif_write, 1'b0);
      chk("reset_outstanding", rd_outstanding, 7'd0);
      step();
      step();
      rst = 0;

      // 1) 32-beat write with emif_waitrequest toggling every cycle
      for (int i = 0; i < 32; i++) begin
         data_arr[i] = rand_word();
         exp_q.push_back(data_arr[i]);
      end
      sb_on = 1;
      acc_cnt = 0;
      k = 0;
      bus.wr_addr = {EMIF_LB_BASE, 25'h0};
      bus.wr_burstcount = 6'd32;
      bus.wr_write = 1;
      bus.wr_wdata = data_arr[0];
      for (int c = 0; c < 200 && acc_cnt < 32; c++) begin
         bus.emif_waitrequest = c[0];
         step();
         if (last_acc_wr) begin
            k++;
            if (k < 32) bus.wr_wdata = data_arr[k];
            else bus.wr_write = 0;
         end
      end
      bus.emif_waitrequest = 0;
      step();
      chk("wr32_beats", acc_cnt, 32);
      chk("wr32_sb_left", exp_q.size(), 0);
      chk("wr32_grant_fall", grant_wr, 1'b0);
      sb_on = 0;

      // 2) both requesting, not urgent: round-robin (reset leaves write as
      //    last grant, so read goes first), one idle cycle between grants
      do_reset();
      g_who.delete(); g_cyc.delete();
      log_on = 1;
      bus.wr_burstcount = 6'd1; bus.wr_write = 1; bus.wr_wdata = rand_word();
      bus.rd_burstcount = 6'd1; bus.rd_read = 1; bus.rd_addr = {EMIF_LB_BASE, 25'h40};
      for (int i = 0; i < 8; i++) step();
      log_on = 0;
      bus.wr_write = 0; bus.rd_read = 0;
      step();
      chk("rr_grant_count", g_who.size(), 4);
      for (int i = 0; i < g_who.size(); i++) begin
         chk("rr_grant_owner", g_who[i], (i % 2 == 0) ? 2 : 1);
         if (i > 0) chk("rr_grant_gap", g_cyc[i] - g_cyc[i-1], 2);
      end

      // 3) urgent read wins every tie, even straight after a read grant
      g_who.delete(); g_cyc.delete();
      log_on = 1;
      bus.rd_urgent = 1; bus.wr_write = 1; bus.rd_read = 1;
      for (int i = 0; i < 6; i++) step();
      log_on = 0;
      bus.wr_write = 0; bus.rd_read = 0; bus.rd_urgent = 0;
      step();
      chk("urgent_grant_count", g_who.size(), 3);
      for (int i = 0; i < g_who.size(); i++) chk("urgent_grant_owner", g_who[i], 2);

      // 4) credit limit: 32 + 32 beats in flight blocks a 1-beat read
      n = m_out;
      drain(n);
      chk("credit_drained", rd_outstanding, 7'd0);
      bus.rd_burstcount = 6'd32; bus.rd_read = 1;
      k = 0;
      for (int c = 0; c < 20 && k < 2; c++) begin
         step();
         if (last_acc_rd) k++;
         if (k == 2) bus.rd_burstcount = 6'd1;
      end
      chk("credit_full", rd_outstanding, 7'd64);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("credit_stall", grant_rd, 1'b0);
      end
      bus.emif_readdatavalid = 1; bus.emif_rdata = rand_word();
      step();
      bus.emif_readdatavalid = 0;
      chk("credit_return", rd_outstanding, 7'd63);
      step();
      chk("credit_regrant", grant_rd, 1'b1);
      step();
      bus.rd_read = 0;
      chk("credit_refill", rd_outstanding, 7'd64);

      // 5) accept bc=16 in the same cycle a beat returns, counter at 10
      drain(54);
      chk("same_cycle_start", rd_outstanding, 7'd10);
      bus.rd_burstcount = 6'd16; bus.rd_read = 1;
      step();
      bus.emif_readdatavalid = 1;
      step();
      bus.emif_readdatavalid = 0; bus.rd_read = 0;
      chk("same_cycle_count", rd_outstanding, 7'd25);

      // 6) reset during beat 5 of a 20-beat write, then a fresh burst
      bus.wr_burstcount = 6'd20; bus.wr_write = 1; bus.wr_wdata = rand_word();
      acc_cnt = 0;
      for (int c = 0; c < 40 && acc_cnt < 4; c++) step();
      rst = 1;
      model_reset();
      #1;
      chk("midrst_emif_write", bus.emif_write, 1'b0);
      chk("midrst_wr_wait", bus.wr_waitrequest, 1'b1);
      chk("midrst_grant_wr", grant_wr, 1'b0);
      chk("midrst_outstanding", rd_outstanding, 7'd0);
      step();
      rst = 0;
      bus.wr_burstcount = 6'd3;
      acc_cnt = 0;
      for (int c = 0; c < 20 && acc_cnt < 3; c++) step();
      bus.wr_write = 0;
      step();
      step();
      chk("postrst_beats", acc_cnt, 3);
      chk("postrst_grant_fall", grant_wr, 1'b0);

      // 7) randomized traffic, including illegal burstcounts and underflow
      for (int i = 0; i < 400; i++) begin
         bus.wr_write = ($urandom_range(0, 2) != 0);
         bus.wr_burstcount = 6'($urandom_range(0, 40));
         bus.wr_addr = 28'($urandom);
         bus.wr_wdata = rand_word();
         bus.rd_read = ($urandom_range(0, 2) != 0);
         bus.rd_burstcount = 6'($urandom_range(0, 40));
         bus.rd_addr = 28'($urandom);
         bus.rd_urgent = ($urandom_range(0, 3) == 0);
         bus.emif_waitrequest = ($urandom_range(0, 2) == 0);
         bus.emif_readdatavalid = ($urandom_range(0, 3) == 0);
         bus.emif_rdata = rand_word();
         step();
      end
      idle_inputs();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
